// File: rtl/ps2_keyboard_controller_if.sv
// CPU-side read bus of the PS/2 keyboard controller.
// The CPU is the master; the controller is the slave.
interface ps2_keyboard_controller_if;
    logic [31:0] raddr;
    logic        rd;
    logic [31:0] rdata;
    logic        ready;

    modport master (output raddr, rd, input rdata, ready);
    modport slave  (input raddr, rd, output rdata, ready);
endinterface

// File: rtl/ps2_keyboard_controller.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit scancode frames,
// and buffers the bytes in a FIFO that the CPU reads through DATA/STATUS registers.
module ps2_keyboard_controller #(
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    ps2_keyboard_controller_if.slave          bus
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic clk_s1, sync_clk, prev_clk;
    logic data_s1, sync_data;
    logic fall;

    state_t        state, state_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [2:0]    bitcnt, bitcnt_nx;
    logic          perr, perr_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic          push_req, frame_err;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wptr, rptr;
    logic               empty, full, pop, push_ok;
    logic               err, ovf, st_clr;
    logic               unused_raddr;

    assign unused_raddr = ^{bus.raddr[31:3], bus.raddr[1:0]};

    // Preset to 1 so that leaving reset with an idle bus never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1    <= 1'b1;
            sync_clk  <= 1'b1;
            prev_clk  <= 1'b1;
            data_s1   <= 1'b1;
            sync_data <= 1'b1;
        end else begin
            clk_s1    <= ps2_clk;
            sync_clk  <= clk_s1;
            prev_clk  <= sync_clk;
            data_s1   <= ps2_data;
            sync_data <= data_s1;
        end
    end

    assign fall = prev_clk & ~sync_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            perr   <= 1'b0;
            tcnt   <= '0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            bitcnt <= bitcnt_nx;
            perr   <= perr_nx;
            tcnt   <= tcnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        bitcnt_nx = bitcnt;
        perr_nx   = perr;
        push_req  = 1'b0;
        frame_err = 1'b0;
        tcnt_nx   = (fall || state == S_IDLE) ? '0 : tcnt + 1'b1;
        if (fall) begin
            unique case (state)
                S_IDLE: begin
                    if (!sync_data) begin
                        state_nx  = S_DATA;
                        bitcnt_nx = '0;
                    end
                end
                S_DATA: begin
                    shreg_nx  = {sync_data, shreg[7:1]};
                    bitcnt_nx = bitcnt + 1'b1;
                    if (bitcnt == 3'd7)
                        state_nx = S_PARITY;
                end
                S_PARITY: begin
                    perr_nx  = ~(^shreg ^ sync_data);
                    state_nx = S_STOP;
                end
                S_STOP: begin
                    if (sync_data && !perr)
                        push_req = 1'b1;
                    else
                        frame_err = 1'b1;
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (state != S_IDLE && tcnt == TLAST) begin
            state_nx  = S_IDLE;
            frame_err = 1'b1;
        end
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]) && (wptr[FIFO_AW] != rptr[FIFO_AW]);
    assign pop     = bus.rd & ~bus.raddr[2] & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign push_ok = push_req & (~full | pop);
    assign st_clr  = bus.rd & bus.raddr[2];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr[FIFO_AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            err  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (frame_err)
                err <= 1'b1;
            else if (st_clr)
                err <= 1'b0;
            if (push_req && !push_ok)
                ovf <= 1'b1;
            else if (st_clr)
                ovf <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.raddr[2])
            bus.rdata = {28'b0, err, ovf, full, ~empty};
        else if (!empty)
            bus.rdata = {24'b0, mem[rptr[FIFO_AW-1:0]]};
    end

    assign bus.ready = ~empty;
endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// Directed plus randomized bench for ps2_keyboard_controller, checked against a queue-based
// model of the FIFO and sticky flags. The PS/2 clock is scaled down to keep runs short.
module tb_ps2_keyboard_controller;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned TMO   = 200;
    localparam int unsigned HP    = 20;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk, ps2_data;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] q[$];
    logic       m_err, m_ovf;

    always #5 clk = ~clk;

    ps2_keyboard_controller_if bus ();

    ps2_keyboard_controller #(.FIFO_AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {28'b0, m_err, m_ovf, q.size() == DEPTH, q.size() != 0};
    endfunction

    task automatic check_status(input string tag);
        @(negedge clk);
        bus.raddr = 32'h4;
        #1;
        chk(tag, bus.rdata, exp_status());
        chk({tag, "_ready"}, {31'b0, bus.ready}, {31'b0, q.size() != 0});
    endtask

    task automatic clear_status(input string tag);
        @(negedge clk);
        bus.raddr = 32'h4;
        #1;
        chk(tag, bus.rdata, exp_status());
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        m_err  = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        @(negedge clk);
        bus.raddr = 32'h0;
        #1;
        e = (q.size() != 0) ? {24'b0, q[0]} : 32'h0;
        chk(tag, bus.rdata, e);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        if (q.size() != 0)
            void'(q.pop_front());
    endtask

    // One PS/2 bit: data changes mid-high, then a low phase. With pop set, a DATA read is
    // timed to hit the same clk edge on which the receiver acts on this falling edge.
    task automatic send_bit(input logic b, input bit pop);
        @(negedge clk);
        ps2_data = b;
        repeat (HP / 2) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop) begin
            @(negedge clk);
            @(negedge clk);
            bus.raddr = 32'h0;
            #1;
            chk("pop_at_stop", bus.rdata, (q.size() != 0) ? {24'b0, q[0]} : 32'h0);
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
            if (q.size() != 0)
                void'(q.pop_front());
        end
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HP / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_stop);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i], 0);
        send_bit((~^b) ^ bad_par, 0);
        send_bit(1'b1, pop_at_stop);
        if (bad_par)
            m_err = 1'b1;
        else if (q.size() < DEPTH)
            q.push_back(b);
        else
            m_ovf = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        bus.raddr = '0;
        bus.rd    = 1'b0;
        m_err     = 1'b0;
        m_ovf     = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("reset_ready", {31'b0, bus.ready}, 32'h0);
        chk("reset_data", bus.rdata, 32'h0);
        rst = 1'b0;
        check_status("reset_status");

        // Good frame, then pop it.
        send_frame(8'h1C, 0, 0);
        check_status("t1_status");
        pop_check("t1_data");
        pop_check("t1_empty_data");
        check_status("t1_after_pop");

        // Parity error sets err, status read clears it.
        send_frame(8'h1C, 1, 0);
        clear_status("t2_status");
        check_status("t2_cleared");

        // Overflow: nine frames, eight slots.
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 0, 0);
        check_status("t3_status");
        for (int i = 0; i < 8; i++)
            pop_check("t3_drain");
        clear_status("t3_status_empty");

        // Partial frame times out.
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++)
            send_bit(1'(i), 0);
        m_err = 1'b1;
        repeat (TMO + 100) @(negedge clk);
        check_status("t4_timeout");
        send_frame(8'hF0, 0, 0);
        check_status("t4_after");
        pop_check("t4_data");
        clear_status("t4_clear");

        // Push into a full FIFO while the same edge pops.
        for (int i = 0; i < 8; i++)
            send_frame(8'(8'h30 + i), 0, 0);
        check_status("t5_full");
        send_frame(8'hA5, 0, 1);
        check_status("t5_after");
        for (int i = 0; i < 8; i++)
            pop_check("t5_drain");
        check_status("t5_empty");

        // Reset in the middle of a frame.
        send_frame(8'h77, 0, 0);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++)
            send_bit(1'b1, 0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        bus.raddr = 32'h0;
        #1;
        chk("t6_data_in_rst", bus.rdata, 32'h0);
        rst = 1'b0;
        check_status("t6_status");
        send_frame(8'h5A, 0, 0);
        check_status("t6_after");
        pop_check("t6_data");

        // Randomized frames and reads.
        for (int n = 0; n < 14; n++) begin
            rb   = 8'($urandom);
            rbad = ($urandom_range(0, 3) == 0);
            send_frame(rb, rbad, 0);
            case ($urandom_range(0, 2))
                0:       pop_check("rand_pop");
                1:       clear_status("rand_clear");
                default: check_status("rand_status");
            endcase
        end
        while (q.size() != 0)
            pop_check("rand_drain");
        check_status("final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
